mult3_sched: RTL

Arbitrated front end for the serial divisible-by-3 datapath. Two requesters each present a parallel WIDTH-bit word. The block grants one requester at a time with round-robin fairness and shifts the word MSB-first through a serial mod-3 remainder tracker. It then returns a one-cycle result tagged with the requester id. It replaces hand-sequenced bit streaming and reset pulsing of the checker by each client.

---
 rtl/mult3_sched_pkg.sv | 25 ++
 rtl/mult3_sched_if.sv | 34 +++
 rtl/mult3_defs.vh | 22 ++
 rtl/mult3_sched_mod3_step.sv | 33 +++
 rtl/mult3_sched.sv | 122 ++++++++++++
 5 files changed

// File: rtl/mult3_sched_pkg.sv
// ============================================================================
//  mult3_sched_pkg
//  Types and constants shared by the mult3_sched design files.
//  Revision: 1.0 - initial release
// ============================================================================
`include "mult3_defs.vh"
`default_nettype none

package mult3_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = `M3_IDLE,
    SHIFT  = `M3_SHIFT,
    REPORT = `M3_REPORT
  } state_t;

  localparam logic [1:0] R0 = `M3_R0;
  localparam logic [1:0] R1 = `M3_R1;
  localparam logic [1:0] R2 = `M3_R2;

  localparam int DEFAULT_WIDTH = `M3_WIDTH;

endpackage

`default_nettype wire

// File: rtl/mult3_sched_if.sv
// ============================================================================
//  mult3_sched_if
//  Requester-side bus of mult3_sched: two request/data pairs in, ack pulses
//  and a tagged divisible-by-3 result out.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult3_sched_if
  import mult3_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       ack;
  logic             done;
  logic             div3;
  logic             done_id;
  logic             busy;

  modport master (
    output req, data0, data1,
    input  ack, done, div3, done_id, busy
  );

  modport slave (
    input  req, data0, data1,
    output ack, done, div3, done_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/mult3_defs.vh
// ============================================================================
//  mult3_defs.vh
//  Shared encodings for the arbitrated serial divisible-by-3 front end:
//  FSM state codes, remainder codes and the default word width.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`ifndef MULT3_DEFS_VH
`define MULT3_DEFS_VH

`define M3_IDLE   2'd0
`define M3_SHIFT  2'd1
`define M3_REPORT 2'd2

`define M3_R0 2'd0
`define M3_R1 2'd1
`define M3_R2 2'd2

`define M3_WIDTH 8

`endif
`default_nettype wire

// File: rtl/mult3_sched_mod3_step.sv
// ============================================================================
//  mod3_step
//  One step of the MSB-first serial remainder rule:
//  rem_next = (2*rem + b) mod 3, with rem restricted to 0, 1, 2.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod3_step
  import mult3_sched_pkg::*;
(
  input  logic [1:0] rem,
  input  logic       b,
  output logic [1:0] rem_next
);

  // Six legal {rem, b} combinations; the unused code 3 folds to zero.
  always_comb begin
    rem_next = R0;
    case ({rem, b})
      3'b000:  rem_next = R0;
      3'b001:  rem_next = R1;
      3'b010:  rem_next = R2;
      3'b011:  rem_next = R0;
      3'b100:  rem_next = R1;
      3'b101:  rem_next = R2;
      default: rem_next = R0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mult3_sched.sv
// ============================================================================
//  mult3_sched
//  Round-robin arbiter for two requesters feeding a serial mod-3 tracker.
//  The granted word is shifted MSB-first; a one-cycle done pulse reports
//  divisibility by 3 together with the requester id.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult3_sched
  import mult3_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  mult3_sched_if.slave bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [1:0]       rem, rem_next, rem_step;
  logic [CW-1:0]    cnt, cnt_next;
  logic             gid, gid_next;
  logic             prio, prio_next;
  logic             grant;
  logic [1:0]       ack_reg, ack_next;
  logic             done_reg, done_next;
  logic             div3_reg, div3_next;
  logic             done_id_reg, done_id_next;

  mod3_step u_step (
    .rem      (rem),
    .b        (shreg[WIDTH-1]),
    .rem_next (rem_step)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    rem_next     = rem;
    cnt_next     = cnt;
    gid_next     = gid;
    prio_next    = prio;
    ack_next     = 2'b00;
    done_next    = 1'b0;
    div3_next    = div3_reg;
    done_id_next = done_id_reg;
    // Single requester wins outright; a tie goes to the priority holder.
    grant        = (bus.req == 2'b11) ? prio : bus.req[1];
    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          shreg_next      = grant ? bus.data1 : bus.data0;
          rem_next        = R0;
          cnt_next        = '0;
          gid_next        = grant;
          ack_next[grant] = 1'b1;
          prio_next       = ~grant;
          state_next      = SHIFT;
        end
      end
      SHIFT: begin
        rem_next   = rem_step;
        shreg_next = shreg << 1;
        cnt_next   = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_next   = REPORT;
          done_next    = 1'b1;
          div3_next    = (rem_step == R0);
          done_id_next = gid;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      rem         <= R0;
      cnt         <= '0;
      gid         <= 1'b0;
      prio        <= 1'b0;
      ack_reg     <= 2'b00;
      done_reg    <= 1'b0;
      div3_reg    <= 1'b0;
      done_id_reg <= 1'b0;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      rem         <= rem_next;
      cnt         <= cnt_next;
      gid         <= gid_next;
      prio        <= prio_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      div3_reg    <= div3_next;
      done_id_reg <= done_id_next;
    end
  end

  assign bus.ack     = ack_reg;
  assign bus.done    = done_reg;
  assign bus.div3    = div3_reg;
  assign bus.done_id = done_id_reg;
  assign bus.busy    = (state != IDLE);

endmodule

`default_nettype wire
